// File: rtl/mem_access_unit.sv
// Memory-access stage: req/ack data-RAM transaction with load formatting and pipeline stall.
// Optional MEM_TIMEOUT_EN: abort a request with a bus_err pulse after TIMEOUT_CYCLES REQ cycles.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_result,
  input  logic [31:0] rt_data,
  input  logic        cu_m2reg,
  input  logic        cu_wmem,
  input  logic [1:0]  cu_memsize,
  input  logic        cu_memsign,
  output logic        ram_req,
  output logic        ram_we,
  output logic [29:0] ram_addr,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic        ram_ack,
  input  logic [31:0] ram_rdata,
  output logic [31:0] ram_data,
  output logic        mem_stall,
  output logic        misalign_exc,
  output logic        bus_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [1:0]  state;
  logic        mem_op, is_half, is_word, access, timeout;
  logic [3:0]  be_next;
  logic [31:0] wdata_next, rd_shift, load_fmt;

  assign mem_op       = cu_m2reg | cu_wmem;
  assign is_half      = (cu_memsize == 2'b01);
  assign is_word      = cu_memsize[1];
  assign misalign_exc = mem_op & ((is_half & alu_result[0]) |
                                  (is_word & (alu_result[1:0] != 2'b00)));
  assign access       = mem_op & ~misalign_exc;
  assign mem_stall    = access & (state != DONE);

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = rt_data;
    if (cu_memsize == 2'b00) begin
      be_next    = 4'b0001 << alu_result[1:0];
      wdata_next = {4{rt_data[7:0]}};
    end else if (is_half) begin
      be_next    = 4'b0011 << alu_result[1:0];
      wdata_next = {2{rt_data[15:0]}};
    end
  end

  // The instruction is held by mem_stall, so its offset/size/sign are still valid at ack time.
  always_comb begin
    rd_shift = ram_rdata >> {alu_result[1:0], 3'b000};
    load_fmt = ram_rdata;
    if (cu_memsize == 2'b00)
      load_fmt = {{24{cu_memsign & rd_shift[7]}}, rd_shift[7:0]};
    else if (is_half)
      load_fmt = {{16{cu_memsign & rd_shift[15]}}, rd_shift[15:0]};
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] to_cnt;

  assign timeout = (state == REQ) & ~ram_ack & (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= timeout;
      if (state != REQ)
        to_cnt <= '0;
      else if (!ram_ack)
        to_cnt <= to_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_be    <= '0;
      ram_wdata <= '0;
      ram_data  <= '0;
    end else begin
      case (state)
        IDLE: if (access) begin
          ram_req   <= 1'b1;
          ram_we    <= cu_wmem;
          ram_addr  <= alu_result[31:2];
          ram_be    <= be_next;
          ram_wdata <= wdata_next;
          state     <= REQ;
        end
        REQ: if (ram_ack) begin
          ram_req <= 1'b0;
          ram_we  <= 1'b0;
          if (!ram_we) ram_data <= load_fmt;
          state   <= DONE;
        end else if (timeout) begin
          ram_req <= 1'b0;
          ram_we  <= 1'b0;
          if (!ram_we) ram_data <= '0;
          state   <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
